v_ram: RTL

Vector RAM responder for the vector issue path: it sits on the far side of the vector memory-access adapter. It accepts the adapter's full-width read and write requests (read enable, write enable, byte address, bit mask, write data) and returns registered read data one cycle later. After reset it zero-fills its storage with an internal sweep before it accepts requests. Misaligned and out-of-range accesses are flagged rather than silently aliased.

---
 rtl/v_ram_pkg.sv | 27 ++
 rtl/v_ram_array.sv | 40 ++++
 rtl/v_ram.sv | 112 +++++++++++
 3 files changed

// File: rtl/v_ram_pkg.sv
// Shared types and address-geometry helpers for the vector RAM responder.
// The top derives its own geometry from its parameters through these functions.
package v_ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int calc_bytes(input int dw);
    return dw / 8;
  endfunction

  function automatic int calc_offw(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int calc_idxw(input int depth);
    return $clog2(depth);
  endfunction

  // Geometry of the default 256-bit x 64-word configuration.
  localparam int BYTES = calc_bytes(256);
  localparam int OFFW  = calc_offw(256);
  localparam int IDXW  = calc_idxw(64);

endpackage

// File: rtl/v_ram_array.sv
// Flop-based word storage with a per-bit masked write port and a read-first
// registered read port; rdata holds its value when no read is issued.
module v_ram_array #(
  parameter int DW    = 256,
  parameter int DEPTH = 64,
  parameter int IDXW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [IDXW-1:0] widx_i,
  input  logic [DW-1:0]   wmask_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic            re_i,
  input  logic [IDXW-1:0] ridx_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] wword_d;
  logic [DW-1:0] rdata_q, rdata_d;

  always_comb begin
    wword_d = (mem_q[widx_i] & ~wmask_i) | (wdata_i & wmask_i);
    rdata_d = re_i ? mem_q[ridx_i] : rdata_q;
  end

  // Storage carries no reset; the top's clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx_i] <= wword_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/v_ram.sv
// Vector RAM responder: clears its storage after reset, then services legal
// full-width masked writes and read-first registered reads, flagging bad addresses.
module v_ram
  import v_ram_pkg::*;
#(
  parameter int VRAM_DW = 256,
  parameter int VRAM_AW = 32,
  parameter int DEPTH   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vram_ren_i,
  input  logic               vram_wen_i,
  input  logic [VRAM_AW-1:0] vram_addr_i,
  input  logic [VRAM_DW-1:0] vram_mask_i,
  input  logic [VRAM_DW-1:0] vram_din_i,
  output logic [VRAM_DW-1:0] vram_dout_o,
  output logic               vram_rvalid_o,
  output logic               vram_err_o,
  output logic               vram_ready_o
);

  localparam int NBYTES = calc_bytes(VRAM_DW);
  localparam int OFF_W  = calc_offw(VRAM_DW);
  localparam int IDX_W  = calc_idxw(DEPTH);
  localparam logic [VRAM_AW-1:0] OFF_MASK = VRAM_AW'(NBYTES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;

  logic [IDX_W-1:0]   req_idx;
  logic               legal;
  logic               ready;
  logic               arr_we;
  logic [IDX_W-1:0]   arr_widx;
  logic [VRAM_DW-1:0] arr_wmask;
  logic [VRAM_DW-1:0] arr_wdata;
  logic               arr_re;

  // Aligned and inside the array: no offset bits, nothing above the index field.
  assign req_idx = vram_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign legal   = ((vram_addr_i & OFF_MASK) == '0) &&
                   ((vram_addr_i >> (OFF_W + IDX_W)) == '0);
  assign ready   = (state_q == READY);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    arr_we    = 1'b0;
    arr_widx  = req_idx;
    arr_wmask = vram_mask_i;
    arr_wdata = vram_din_i;
    arr_re    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        arr_we    = 1'b1;
        arr_widx  = clr_cnt_q;
        arr_wmask = '1;
        arr_wdata = '0;
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == LAST_IDX) state_d = READY;
      end
      READY: begin
        arr_we   = vram_wen_i && legal;
        arr_re   = vram_ren_i && legal;
        rvalid_d = vram_ren_i && legal;
        err_d    = (vram_ren_i || vram_wen_i) && !legal;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  v_ram_array #(
    .DW    (VRAM_DW),
    .DEPTH (DEPTH),
    .IDXW  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we),
    .widx_i  (arr_widx),
    .wmask_i (arr_wmask),
    .wdata_i (arr_wdata),
    .re_i    (arr_re),
    .ridx_i  (req_idx),
    .rdata_o (vram_dout_o)
  );

  assign vram_rvalid_o = rvalid_q;
  assign vram_err_o    = err_q;
  assign vram_ready_o  = ready;

endmodule
